// File: rtl/uc_escalonador_quadro.sv
// rtl/uc_escalonador_quadro.sv - per-frame phase scheduler for the game datapath
//
// On every frame tick this unit runs, in order: move shots, move asteroids,
// shot/asteroid compare, ship collision and render. Each phase receives a
// one-clock start strobe, and the scheduler then waits for that phase's done
// pulse before moving on. It is the only source of the phase start strobes.
//
// Ports
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   jogando                       game running; 0 stops scheduling new frames
//   fim_mov_tiros ..fim_render    done pulses from the five phase units
//   move_tiros ..renderiza        one-clock start strobes to the five phase units
//   quadro_ativo                  high from START_MT through FIM_QUADRO
//   quadro_atrasado               sticky: a frame tick arrived while a frame was active
//   erro_timeout                  high while in ERRO (a phase never answered)
//   contagem_quadros              completed frames, wraps 255 -> 0
//   db_estado                     current state code, for debug
module uc_escalonador_quadro #(
  parameter int TICKS_QUADRO = 50000,
  parameter int TIMEOUT      = 4096,
  parameter int W_TICK       = 16,
  parameter int W_TO         = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogando,
  input  logic       fim_mov_tiros,
  input  logic       fim_mov_asteroides,
  input  logic       fim_comparacao,
  input  logic       fim_colisao_nave,
  input  logic       fim_render,
  output logic       move_tiros,
  output logic       move_asteroides,
  output logic       compara_tiros_e_asteroides,
  output logic       verifica_nave,
  output logic       renderiza,
  output logic       quadro_ativo,
  output logic       quadro_atrasado,
  output logic       erro_timeout,
  output logic [7:0] contagem_quadros,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIO     = 4'h0,
    ESPERA     = 4'h1,
    START_MT   = 4'h2,
    WAIT_MT    = 4'h3,
    START_MA   = 4'h4,
    WAIT_MA    = 4'h5,
    START_CMP  = 4'h6,
    WAIT_CMP   = 4'h7,
    START_NV   = 4'h8,
    WAIT_NV    = 4'h9,
    START_RD   = 4'hA,
    WAIT_RD    = 4'hB,
    FIM_QUADRO = 4'hC,
    ERRO       = 4'hF
  } estado_t;

  estado_t           estado;
  estado_t           estado_prox;
  logic [W_TICK-1:0] tick_cnt;
  logic              tick_pend;
  logic              tick_wrap;
  logic [W_TO-1:0]   to_cnt;
  logic              em_espera_fim;
  logic              fim_fase;
  logic              to_esgotado;
  logic              inicia_quadro;
  estado_t           apos_fase;

  assign tick_wrap     = jogando && (tick_cnt == W_TICK'(TICKS_QUADRO - 1));
  assign to_esgotado   = (to_cnt == W_TO'(TIMEOUT - 1));
  assign inicia_quadro = (estado == ESPERA) && (estado_prox == START_MT);

  // Select the done pulse of the phase currently being waited on; done pulses
  // of any other phase, or outside WAIT states, are never looked at.
  always_comb begin
    em_espera_fim = 1'b1;
    fim_fase      = 1'b0;
    apos_fase     = ESPERA;
    case (estado)
      WAIT_MT:  begin fim_fase = fim_mov_tiros;      apos_fase = START_MA;   end
      WAIT_MA:  begin fim_fase = fim_mov_asteroides; apos_fase = START_CMP;  end
      WAIT_CMP: begin fim_fase = fim_comparacao;     apos_fase = START_NV;   end
      WAIT_NV:  begin fim_fase = fim_colisao_nave;   apos_fase = START_RD;   end
      WAIT_RD:  begin fim_fase = fim_render;         apos_fase = FIM_QUADRO; end
      default:  em_espera_fim = 1'b0;
    endcase
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIO:     estado_prox = ESPERA;
      ESPERA:     if (jogando && tick_pend) estado_prox = START_MT;
      START_MT:   estado_prox = WAIT_MT;
      START_MA:   estado_prox = WAIT_MA;
      START_CMP:  estado_prox = WAIT_CMP;
      START_NV:   estado_prox = WAIT_NV;
      START_RD:   estado_prox = WAIT_RD;
      FIM_QUADRO: estado_prox = ESPERA;
      ERRO:       estado_prox = ERRO;
      default: begin
        if (em_espera_fim) begin
          // A done pulse beats the timeout in the same cycle. If the game
          // stopped mid-frame, the finished phase drops back to ESPERA and
          // the frame is not counted.
          if (fim_fase)         estado_prox = jogando ? apos_fase : ESPERA;
          else if (to_esgotado) estado_prox = ERRO;
        end else begin
          estado_prox = ERRO;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Timeout counter runs only inside WAIT states; every START state zeroes it
  // so each WAIT state is entered with a fresh count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (em_espera_fim) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Frame period counter. A wrap that lands on the ESPERA->START_MT cycle is a
  // fresh tick, so setting tick_pend takes priority over clearing it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
    end else if (!jogando) begin
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      if (tick_wrap)          tick_pend <= 1'b1;
      else if (inicia_quadro) tick_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quadro_atrasado  <= 1'b0;
      contagem_quadros <= 8'd0;
    end else begin
      if (tick_wrap && quadro_ativo) quadro_atrasado <= 1'b1;
      if (estado == FIM_QUADRO)      contagem_quadros <= contagem_quadros + 8'd1;
    end
  end

  assign move_tiros                 = (estado == START_MT);
  assign move_asteroides            = (estado == START_MA);
  assign compara_tiros_e_asteroides = (estado == START_CMP);
  assign verifica_nave              = (estado == START_NV);
  assign renderiza                  = (estado == START_RD);
  assign quadro_ativo               = (estado >= START_MT) && (estado <= FIM_QUADRO);
  assign erro_timeout               = (estado == ERRO);
  assign db_estado                  = estado;

endmodule

// File: tb/tb_uc_escalonador_quadro.sv
// tb/tb_uc_escalonador_quadro.sv - directed self-checking bench for uc_escalonador_quadro
module tb_uc_escalonador_quadro;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogando;
  logic [4:0] d;
  logic       move_tiros, move_asteroides, compara_tiros_e_asteroides, verifica_nave, renderiza;
  logic       quadro_ativo, quadro_atrasado, erro_timeout;
  logic [7:0] contagem_quadros;
  logic [3:0] db_estado;
  logic [4:0] strobes;

  int n_chk  = 0;
  int n_fail = 0;

  uc_escalonador_quadro #(
    .TICKS_QUADRO(16),
    .TIMEOUT     (8),
    .W_TICK      (5),
    .W_TO        (3)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .jogando                    (jogando),
    .fim_mov_tiros              (d[0]),
    .fim_mov_asteroides         (d[1]),
    .fim_comparacao             (d[2]),
    .fim_colisao_nave           (d[3]),
    .fim_render                 (d[4]),
    .move_tiros                 (move_tiros),
    .move_asteroides            (move_asteroides),
    .compara_tiros_e_asteroides (compara_tiros_e_asteroides),
    .verifica_nave              (verifica_nave),
    .renderiza                  (renderiza),
    .quadro_ativo               (quadro_ativo),
    .quadro_atrasado            (quadro_atrasado),
    .erro_timeout               (erro_timeout),
    .contagem_quadros           (contagem_quadros),
    .db_estado                  (db_estado)
  );

  assign strobes = {renderiza, verifica_nave, compara_tiros_e_asteroides, move_asteroides, move_tiros};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int i = 0;
    while (db_estado !== code && i < budget) begin
      @(negedge clock);
      i++;
    end
    chk(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  // Entered at the negedge inside START of phase p; leaves at the negedge of
  // the state following that phase's WAIT.
  task automatic do_phase(input int p, input int dly);
    chk("start_state", {28'd0, db_estado}, 32'(2 + 2 * p));
    chk("strobe", {27'd0, strobes}, 32'(1 << p));
    chk("ativo", {31'd0, quadro_ativo}, 32'd1);
    @(negedge clock);
    chk("wait_state", {28'd0, db_estado}, 32'(3 + 2 * p));
    repeat (dly) @(negedge clock);
    d = 5'(1 << p);
    @(negedge clock);
    d = 5'd0;
  endtask

  task automatic run_frame(input logic [14:0] dly);
    wait_state(4'h2, 64, "frame_start");
    for (int p = 0; p < 5; p++) do_phase(p, int'(dly[p*3 +: 3]));
    chk("fim_quadro", {28'd0, db_estado}, 32'hC);
    @(negedge clock);
    chk("back_espera", {28'd0, db_estado}, 32'h1);
  endtask

  initial begin
    logic [4:0] seen;
    reset   = 1'b1;
    jogando = 1'b0;
    d       = 5'd0;
    repeat (2) @(negedge clock);
    chk("rst_state",     {28'd0, db_estado},        32'h0);
    chk("rst_strobes",   {27'd0, strobes},          32'h0);
    chk("rst_ativo",     {31'd0, quadro_ativo},     32'h0);
    chk("rst_erro",      {31'd0, erro_timeout},     32'h0);
    chk("rst_count",     {24'd0, contagem_quadros}, 32'h0);
    chk("rst_atrasado",  {31'd0, quadro_atrasado},  32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("inicio_to_espera", {28'd0, db_estado}, 32'h1);
    jogando = 1'b1;

    // Fast frame: every done on the first WAIT cycle
    run_frame(15'd0);
    chk("count_one_frame", {24'd0, contagem_quadros}, 32'd1);
    chk("not_late_fast",   {31'd0, quadro_atrasado},  32'd0);

    // Early compare done ignored, then compare timeout
    wait_state(4'h2, 64, "frame2_start");
    do_phase(0, 0);
    do_phase(1, 0);
    chk("cmp_strobe", {27'd0, strobes}, 32'h4);
    d = 5'b00100;
    @(negedge clock);
    d = 5'd0;
    chk("cmp_early_ignored", {28'd0, db_estado}, 32'h7);
    repeat (7) @(negedge clock);
    chk("cmp_last_wait", {28'd0, db_estado}, 32'h7);
    @(negedge clock);
    chk("timeout_state", {28'd0, db_estado},    32'hF);
    chk("timeout_erro",  {31'd0, erro_timeout}, 32'd1);
    seen = 5'd0;
    repeat (10) begin
      @(negedge clock);
      seen = seen | strobes;
    end
    chk("erro_hold",      {28'd0, db_estado},        32'hF);
    chk("erro_no_strobe", {27'd0, seen},             32'h0);
    chk("erro_count",     {24'd0, contagem_quadros}, 32'd1);

    // Late frame: render delayed past the next tick wrap
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_frame({3'd6, 3'd3, 3'd0, 3'd0, 3'd0});
    chk("late_flag",  {31'd0, quadro_atrasado},  32'd1);
    chk("late_count", {24'd0, contagem_quadros}, 32'd1);
    @(negedge clock);
    chk("late_next_start", {28'd0, db_estado}, 32'h2);

    // jogando drops during WAIT_MA
    do_phase(0, 0);
    chk("ma_strobe", {27'd0, strobes}, 32'h2);
    @(negedge clock);
    chk("ma_wait", {28'd0, db_estado}, 32'h5);
    jogando = 1'b0;
    @(negedge clock);
    chk("ma_still_wait", {28'd0, db_estado}, 32'h5);
    d = 5'b00010;
    @(negedge clock);
    d = 5'd0;
    chk("abort_to_espera", {28'd0, db_estado}, 32'h1);
    seen = 5'd0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | strobes;
    end
    chk("abort_no_strobe", {27'd0, seen},             32'h0);
    chk("abort_idle",      {28'd0, db_estado},        32'h1);
    chk("abort_count",     {24'd0, contagem_quadros}, 32'd1);

    // Reset during WAIT_NV
    jogando = 1'b1;
    wait_state(4'h2, 64, "frame_nv_start");
    do_phase(0, 0);
    do_phase(1, 0);
    do_phase(2, 0);
    @(negedge clock);
    chk("nv_wait", {28'd0, db_estado}, 32'h9);
    reset = 1'b1;
    #1;
    chk("midrst_state",    {28'd0, db_estado},        32'h0);
    chk("midrst_strobes",  {27'd0, strobes},          32'h0);
    chk("midrst_ativo",    {31'd0, quadro_ativo},     32'h0);
    chk("midrst_count",    {24'd0, contagem_quadros}, 32'h0);
    chk("midrst_atrasado", {31'd0, quadro_atrasado},  32'h0);
    chk("midrst_erro",     {31'd0, erro_timeout},     32'h0);
    @(negedge clock);
    reset = 1'b0;

    // 256 frames wrap the frame counter
    for (int i = 0; i < 256; i++) begin
      run_frame(15'd0);
      if (i == 254) chk("count_255", {24'd0, contagem_quadros}, 32'd255);
    end
    chk("count_wrap", {24'd0, contagem_quadros}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
